// File: rtl/beta_if_prefetch_stage.sv
// Instruction fetch stage: PC generation, pipelined imem requests with bounded
// outstanding count, and a {pc, instr} prefetch buffer feeding decode.
module beta_if_prefetch_stage #(
  parameter int unsigned          DataWidth      = 32,
  parameter int unsigned          FifoDepth      = 4,
  parameter int unsigned          MaxOutstanding = 2,
  parameter logic [DataWidth-1:0] BootAddr       = '0
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         if_fetch_en_i,
  output logic                         if_instr_req_o,
  output logic [DataWidth-1:0]         if_instr_addr_o,
  input  logic                         if_instr_ready_i,
  input  logic                         if_instr_valid_i,
  input  logic [DataWidth-1:0]         if_instr_rdata_i,
  input  logic                         if_ctrl_hazard_flag_i,
  input  logic                         if_trap_hazard_flag_i,
  input  logic [DataWidth-1:0]         if_next_pc_i,
  input  logic                         if_ready_i,
  output logic                         if_new_instr_o,
  output logic [DataWidth-1:0]         if_instr_o,
  output logic [DataWidth-1:0]         if_curr_pc_o,
  output logic                         if_stage_busy_o,
  output logic [$clog2(FifoDepth):0]   if_fifo_level_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [DataWidth-1:0]   fetch_pc_q, fetch_pc_d;
  logic [LvlW-1:0]        outstanding_q, outstanding_d;
  logic [LvlW-1:0]        discard_q, discard_d;
  logic [LvlW-1:0]        level_q, level_d;
  logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [DataWidth-1:0]   pc_mem_q    [FifoDepth];
  logic [DataWidth-1:0]   instr_mem_q [FifoDepth];

  logic                   redirect, resp, accept, push, pop, new_instr;
  logic [LvlW-1:0]        live_cnt;
  logic [LvlW:0]          credit_used;
  logic [DataWidth-1:0]   resp_pc;

  assign redirect    = if_ctrl_hazard_flag_i | if_trap_hazard_flag_i;
  assign resp        = if_instr_valid_i & (outstanding_q != '0);
  assign new_instr   = (level_q != '0);
  assign credit_used = {1'b0, level_q} + {1'b0, outstanding_q};

  assign if_instr_req_o = (state_q == StFetch) & if_fetch_en_i & ~redirect &
                          (outstanding_q < LvlW'(MaxOutstanding)) &
                          (credit_used < (LvlW + 1)'(FifoDepth));
  assign if_instr_addr_o = fetch_pc_q;

  assign accept = if_instr_req_o & if_instr_ready_i;
  assign push   = resp & (discard_q == '0) & ~redirect;
  assign pop    = new_instr & if_ready_i & ~redirect;

  // Live (non-discarded) requests were issued back to back and end just below
  // fetch_pc, so the oldest live request address can be reconstructed.
  assign live_cnt = outstanding_q - discard_q;
  assign resp_pc  = fetch_pc_q - (DataWidth'(live_cnt) << 2);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + LvlW'(accept) - LvlW'(resp);
    discard_d     = discard_q;
    level_d       = level_q + LvlW'(push) - LvlW'(pop);
    state_d       = state_q;

    if (redirect) begin
      fetch_pc_d = if_next_pc_i;
      level_d    = '0;
      // Every request still in flight after this cycle is stale.
      discard_d  = outstanding_q - LvlW'(resp);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + DataWidth'(4);
      if (resp && (discard_q != '0)) discard_d = discard_q - LvlW'(1);
    end

    unique case (state_q)
      StIdle:  if (if_fetch_en_i) state_d = StFetch;
      StFetch: if (redirect && ((outstanding_q - LvlW'(resp)) != '0)) state_d = StDrain;
      StDrain: if (discard_d == '0) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= StIdle;
      fetch_pc_q    <= BootAddr;
      outstanding_q <= '0;
      discard_q     <= '0;
      level_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      level_q       <= level_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(FifoDepth); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= resp_pc;
      instr_mem_q[wr_ptr_q] <= if_instr_rdata_i;
    end
  end

  assign if_new_instr_o  = new_instr;
  assign if_instr_o      = instr_mem_q[rd_ptr_q];
  assign if_curr_pc_o    = pc_mem_q[rd_ptr_q];
  assign if_stage_busy_o = (outstanding_q != '0) | (state_q == StDrain);
  assign if_fifo_level_o = level_q;

endmodule

// File: tb/tb_beta_if_prefetch_stage.sv
// Directed bench for beta_if_prefetch_stage: boot streaming, backpressure,
// hazard draining, fetch disable and mid-burst reset.
module tb_beta_if_prefetch_stage;

  localparam logic [31:0] Key = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_en, req, ready, valid, ctrl, trap, if_ready, new_instr, busy;
  logic [31:0] addr, rdata, next_pc, instr, curr_pc;
  logic [2:0]  level;

  logic        mem_auto, mem_valid, man_valid;
  logic [31:0] mem_rdata, man_rdata;
  int          acc_cnt;
  int          total = 0;
  int          bad = 0;

  assign valid = mem_auto ? mem_valid : man_valid;
  assign rdata = mem_auto ? mem_rdata : man_rdata;

  always #5 clk = ~clk;

  beta_if_prefetch_stage dut (
    .clk_i                 (clk),
    .rstn_i                (rstn),
    .if_fetch_en_i         (fetch_en),
    .if_instr_req_o        (req),
    .if_instr_addr_o       (addr),
    .if_instr_ready_i      (ready),
    .if_instr_valid_i      (valid),
    .if_instr_rdata_i      (rdata),
    .if_ctrl_hazard_flag_i (ctrl),
    .if_trap_hazard_flag_i (trap),
    .if_next_pc_i          (next_pc),
    .if_ready_i            (if_ready),
    .if_new_instr_o        (new_instr),
    .if_instr_o            (instr),
    .if_curr_pc_o          (curr_pc),
    .if_stage_busy_o       (busy),
    .if_fifo_level_o       (level)
  );

  // One-cycle memory: answers each accepted request on the next cycle.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_valid <= 1'b0;
      mem_rdata <= '0;
      acc_cnt   <= 0;
    end else begin
      mem_valid <= mem_auto & req & ready;
      mem_rdata <= addr ^ Key;
      if (req && ready) acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    fetch_en = 0; ready = 0; ctrl = 0; trap = 0; if_ready = 0;
    next_pc = '0; mem_auto = 0; man_valid = 0; man_rdata = '0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_new", 32'(new_instr), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Boot streaming at one instruction per cycle
    fetch_en = 1; ready = 1; if_ready = 1; mem_auto = 1;
    tick(); #1;
    chk("boot_req0", 32'(req), 32'd1);
    chk("boot_addr0", addr, 32'h0);
    tick(); #1;
    chk("boot_addr1", addr, 32'h4);
    chk("boot_new_early", 32'(new_instr), 32'd0);
    tick(); #1;
    chk("boot_new", 32'(new_instr), 32'd1);
    chk("boot_pc0", curr_pc, 32'h0);
    chk("boot_instr0", instr, Key);
    for (int k = 1; k <= 5; k++) begin
      tick(); #1;
      chk("boot_pc", curr_pc, 32'(4 * k));
      chk("boot_instr", instr, 32'(4 * k) ^ Key);
      chk("boot_level", 32'(level), 32'd1);
    end

    // Asynchronous reset mid-burst
    rstn = 1'b0;
    #1;
    chk("mid_rst_req", 32'(req), 32'd0);
    chk("mid_rst_addr", addr, 32'd0);
    chk("mid_rst_new", 32'(new_instr), 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_pc", curr_pc, 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rstn = 1'b1;
    tick(); #1;
    chk("post_rst_req", 32'(req), 32'd1);
    chk("post_rst_addr", addr, 32'h0);

    // Decode stalled: credits allow exactly FifoDepth requests
    do_reset();
    fetch_en = 1; ready = 1; mem_auto = 1; if_ready = 0;
    repeat (8) tick();
    #1;
    chk("bp_accepted", 32'(acc_cnt), 32'd4);
    chk("bp_req", 32'(req), 32'd0);
    chk("bp_level", 32'(level), 32'd4);
    if_ready = 1;
    #1;
    chk("bp_pop0", curr_pc, 32'h0);
    tick(); #1;
    chk("bp_pop4", curr_pc, 32'h4);
    chk("bp_resume_req", 32'(req), 32'd1);
    chk("bp_resume_addr", addr, 32'h10);
    tick(); #1;
    chk("bp_pop8", curr_pc, 32'h8);
    tick(); #1;
    chk("bp_popc", curr_pc, 32'hC);

    // Control hazard with two requests in flight
    do_reset();
    fetch_en = 1; ready = 1; if_ready = 1;
    repeat (3) tick();
    #1;
    chk("ch_cap_req", 32'(req), 32'd0);
    chk("ch_busy", 32'(busy), 32'd1);
    ctrl = 1; next_pc = 32'h100;
    tick();
    ctrl = 0; man_valid = 1; man_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ch_drain_req", 32'(req), 32'd0);
    chk("ch_drain_busy", 32'(busy), 32'd1);
    chk("ch_flush_new", 32'(new_instr), 32'd0);
    tick(); #1;
    chk("ch_drop1_req", 32'(req), 32'd0);
    chk("ch_drop1_new", 32'(new_instr), 32'd0);
    tick();
    man_valid = 0;
    #1;
    chk("ch_redir_req", 32'(req), 32'd1);
    chk("ch_redir_addr", addr, 32'h100);
    chk("ch_level", 32'(level), 32'd0);
    chk("ch_busy_done", 32'(busy), 32'd0);

    // Trap hazard in the same cycle as a response
    do_reset();
    fetch_en = 1; ready = 1; if_ready = 1;
    repeat (3) tick();
    trap = 1; next_pc = 32'h200; man_valid = 1; man_rdata = 32'h0BAD_0BAD;
    tick();
    trap = 0;
    #1;
    chk("tr_new", 32'(new_instr), 32'd0);
    chk("tr_level", 32'(level), 32'd0);
    chk("tr_busy", 32'(busy), 32'd1);
    chk("tr_req", 32'(req), 32'd0);
    tick();
    man_valid = 0;
    #1;
    chk("tr_redir_req", 32'(req), 32'd1);
    chk("tr_redir_addr", addr, 32'h200);
    chk("tr_level_after", 32'(level), 32'd0);

    // Fetch disabled with two requests in flight
    do_reset();
    fetch_en = 1; ready = 1; if_ready = 0;
    repeat (3) tick();
    fetch_en = 0; man_valid = 1; man_rdata = 32'h0 ^ Key;
    #1;
    chk("fe_req", 32'(req), 32'd0);
    chk("fe_busy", 32'(busy), 32'd1);
    tick();
    man_rdata = 32'h4 ^ Key;
    #1;
    chk("fe_level1", 32'(level), 32'd1);
    chk("fe_busy1", 32'(busy), 32'd1);
    tick();
    man_valid = 0;
    #1;
    chk("fe_level2", 32'(level), 32'd2);
    chk("fe_busy_fall", 32'(busy), 32'd0);
    tick(); tick(); #1;
    chk("fe_no_req", 32'(req), 32'd0);
    chk("fe_accepted", 32'(acc_cnt), 32'd2);
    if_ready = 1;
    #1;
    chk("fe_pop0_pc", curr_pc, 32'h0);
    chk("fe_pop0_instr", instr, Key);
    tick(); #1;
    chk("fe_pop1_pc", curr_pc, 32'h4);
    chk("fe_pop1_instr", instr, 32'h4 ^ Key);
    tick(); #1;
    chk("fe_empty", 32'(new_instr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
